ifu: RTL and testbench
======================

IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter: ADDR_WIDTH, `ADDR_WIDTH (32), PC and memory address width.
REQ-002 Parameter: INST_WIDTH, 32, instruction word width.
REQ-003 Parameter: RESET_PC, 32'h8000_0000, first fetch address after reset.
REQ-004 Port: i_sys_clk  in  1  single system clock; all state updates on its rising edge.
REQ-005 Port: i_sys_rst  in  1  reset, synchronous, active-high.
REQ-006 Port: i_jmp_en  in  1  redirect request from execute/commit.
REQ-007 Port: i_jmp_pc  in  ADDR_WIDTH  redirect target.
REQ-008 Port: o_imem_req_valid  out  1  instruction-memory request valid.
REQ-009 Port: i_imem_req_ready  in  1  memory accepts request.
REQ-010 Port: o_imem_req_addr  out  ADDR_WIDTH  fetch address.
REQ-011 Port: i_imem_rsp_valid  in  1  response valid; the memory always accepts, so there is no response ready.
REQ-012 Port: i_imem_rsp_data  in  INST_WIDTH  fetched word.
REQ-013 Port: i_imem_rsp_err  in  1  access fault on the response.
REQ-014 Port: o_ifu_valid  out  1  fetched instruction valid toward ifu2idu.
REQ-015 Port: i_i2i_ready  in  1  ifu2idu accepts.
REQ-016 Port: o_ifu_pc  out  ADDR_WIDTH  PC of the presented instruction.
REQ-017 Port: o_ifu_inst  out  INST_WIDTH  presented instruction.
REQ-018 Port: o_ifu_err  out  1  presented instruction carries an access fault.

Function
REQ-019 FSM states: IDLE, REQ, WAIT, OUT; at most one memory request outstanding.
REQ-020 IDLE: all outputs invalid; unconditionally goes to REQ on the next cycle.
REQ-021 REQ: o_imem_req_valid=1 and o_imem_req_addr=r_pc; on i_imem_req_ready goes to WAIT.
REQ-022 REQ address stable: addr stays constant while valid && !ready, except after a redirect.
REQ-023 WAIT: captures the response on i_imem_rsp_valid and goes to OUT; responses in any other state are ignored.
REQ-024 OUT: o_ifu_valid=1 with registered pc/inst/err held stable until i_i2i_ready.
REQ-025 OUT handshake: on i_i2i_ready goes to REQ with r_pc <= r_pc+4 (modulo 2^ADDR_WIDTH, wraps to 0); back-to-back throughput is one instruction per 3 cycles with zero-wait memory.
REQ-026 Redirect: i_jmp_en in any state sets r_pc <= {i_jmp_pc[ADDR_WIDTH-1:2], 2'b00}.
REQ-027 Redirect in IDLE or REQ: the next request uses the new PC; in REQ with req_ready in the same cycle, the accepted request is treated as stale and the kill flag is set.
REQ-028 Redirect in WAIT: the kill flag is set; the next response is discarded (no OUT) and the FSM goes to REQ.
REQ-029 Redirect in OUT: o_ifu_valid drops the next cycle and the FSM goes to REQ; with simultaneous i_i2i_ready, the current instruction is consumed and the jump target (not pc+4) is fetched next.
REQ-030 Redirect coinciding with a response in WAIT: the response is discarded and no kill flag remains pending.
REQ-031 Response error: o_ifu_err=1 and o_ifu_inst=NOP (32'h0000_0013); PC sequencing is unchanged.

Reset
REQ-032 While i_sys_rst=1: state=IDLE, r_pc=RESET_PC, kill=0, o_imem_req_valid=0, o_imem_req_addr=RESET_PC.
REQ-033 While i_sys_rst=1: o_ifu_valid=0, o_ifu_pc=RESET_PC, o_ifu_inst=NOP, o_ifu_err=0.
REQ-034 Reset mid-transaction: any in-flight response arriving after reset is ignored, because no response is accepted outside WAIT.

Structure
REQ-035 The shared package holds: ADDR_WIDTH, INST_WIDTH, RESET_PC, the NOP constant, and the ifu_state_e enum.
REQ-036 One sub-module, ifu_pcgen: PC register plus next-PC mux (hold / +4 / jump).

Verification
REQ-037 Reset release with zero-wait memory returning 0x00100093 at 0x8000_0000 -> valid out at pc 0x8000_0000 / inst 0x00100093, then a request at 0x8000_0004.
REQ-038 i_i2i_ready held 0 for 5 cycles in OUT -> pc/inst/err stable and no new memory request.
REQ-039 i_jmp_en with pc 0x8000_0102 during WAIT -> response dropped, next request at 0x8000_0100, no valid for the killed word.
REQ-040 i_jmp_en together with i_i2i_ready in OUT, target 0x8000_0040 -> the current instruction is handed off once and the next request is at 0x8000_0040.
REQ-041 Response with i_imem_rsp_err=1 -> o_ifu_err=1, o_ifu_inst=0x0000_0013; r_pc=0xFFFF_FFFC advances to 0x0000_0000.
REQ-042 i_sys_rst asserted while in WAIT, response arriving 1 cycle later -> response ignored and a fresh request at RESET_PC.

Source files
------------

// File: rtl/ifu_pkg.sv
// IFU shared definitions: widths, reset vector, NOP encoding and FSM states.
package ifu_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int INST_WIDTH = 32;

    localparam logic [ADDR_WIDTH-1:0] RESET_PC = 32'h8000_0000;
    localparam logic [INST_WIDTH-1:0] NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } ifu_state_e;

endpackage

// File: rtl/ifu_pcgen.sv
// Fetch PC register with hold / +4 / jump selection.
module ifu_pcgen #(
    parameter int                    ADDR_WIDTH = ifu_pkg::ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ifu_pkg::RESET_PC
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_jmp_en,
    input  logic [ADDR_WIDTH-1:0] i_jmp_pc,
    input  logic                  i_inc,
    output logic [ADDR_WIDTH-1:0] o_pc
);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic                  unused_jmp_lsb;

    // Jump targets are forced word aligned.
    assign unused_jmp_lsb = ^i_jmp_pc[1:0];

    always_comb begin
        pc_d = pc_q;
        unique case (1'b1)
            i_jmp_en: pc_d = {i_jmp_pc[ADDR_WIDTH-1:2], 2'b00};
            i_inc:    pc_d = pc_q + ADDR_WIDTH'(4);
            default:  pc_d = pc_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign o_pc = pc_q;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding memory request, registered
// output toward ifu2idu, redirect with stale-response kill.
module ifu #(
    parameter int                    ADDR_WIDTH = ifu_pkg::ADDR_WIDTH,
    parameter int                    INST_WIDTH = ifu_pkg::INST_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ifu_pkg::RESET_PC
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst,
    input  logic                  i_jmp_en,
    input  logic [ADDR_WIDTH-1:0] i_jmp_pc,
    output logic                  o_imem_req_valid,
    input  logic                  i_imem_req_ready,
    output logic [ADDR_WIDTH-1:0] o_imem_req_addr,
    input  logic                  i_imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] i_imem_rsp_data,
    input  logic                  i_imem_rsp_err,
    output logic                  o_ifu_valid,
    input  logic                  i_i2i_ready,
    output logic [ADDR_WIDTH-1:0] o_ifu_pc,
    output logic [INST_WIDTH-1:0] o_ifu_inst,
    output logic                  o_ifu_err
);

    import ifu_pkg::*;

    ifu_state_e            state_q, state_d;
    logic                  kill_q, kill_d;
    logic [ADDR_WIDTH-1:0] out_pc_q, out_pc_d;
    logic [INST_WIDTH-1:0] out_inst_q, out_inst_d;
    logic                  out_err_q, out_err_d;
    logic                  pc_inc;
    logic [ADDR_WIDTH-1:0] pc;

    ifu_pcgen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pcgen (
        .i_clk    (i_sys_clk),
        .i_rst    (i_sys_rst),
        .i_jmp_en (i_jmp_en),
        .i_jmp_pc (i_jmp_pc),
        .i_inc    (pc_inc),
        .o_pc     (pc)
    );

    always_comb begin
        state_d    = state_q;
        kill_d     = kill_q;
        out_pc_d   = out_pc_q;
        out_inst_d = out_inst_q;
        out_err_d  = out_err_q;
        pc_inc     = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (i_imem_req_ready) begin
                    state_d = S_WAIT;
                    kill_d  = i_jmp_en;
                end
            end
            S_WAIT: begin
                if (i_imem_rsp_valid) begin
                    kill_d = 1'b0;
                    if (i_jmp_en || kill_q) begin
                        state_d = S_REQ;
                    end else begin
                        state_d    = S_OUT;
                        out_pc_d   = pc;
                        out_err_d  = i_imem_rsp_err;
                        out_inst_d = i_imem_rsp_err ? NOP : i_imem_rsp_data;
                    end
                end else if (i_jmp_en) begin
                    kill_d = 1'b1;
                end
            end
            S_OUT: begin
                // A redirect wins over the sequential +4 step.
                if (i_jmp_en || i_i2i_ready) begin
                    state_d = S_REQ;
                    pc_inc  = !i_jmp_en;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state_q    <= S_IDLE;
            kill_q     <= 1'b0;
            out_pc_q   <= RESET_PC;
            out_inst_q <= NOP;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            kill_q     <= kill_d;
            out_pc_q   <= out_pc_d;
            out_inst_q <= out_inst_d;
            out_err_q  <= out_err_d;
        end
    end

    assign o_imem_req_valid = (state_q == S_REQ);
    assign o_imem_req_addr  = pc;
    assign o_ifu_valid      = (state_q == S_OUT);
    assign o_ifu_pc         = out_pc_q;
    assign o_ifu_inst       = out_inst_q;
    assign o_ifu_err        = out_err_q;

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu with a scoreboard of expected handed-off words.
module tb_ifu;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        jmp_en;
    logic [31:0] jmp_pc;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        ifu_valid;
    logic        i2i_ready;
    logic [31:0] ifu_pc;
    logic [31:0] ifu_inst;
    logic        ifu_err;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    ifu dut (
        .i_sys_clk        (clk),
        .i_sys_rst        (rst),
        .i_jmp_en         (jmp_en),
        .i_jmp_pc         (jmp_pc),
        .o_imem_req_valid (req_valid),
        .i_imem_req_ready (req_ready),
        .o_imem_req_addr  (req_addr),
        .i_imem_rsp_valid (rsp_valid),
        .i_imem_rsp_data  (rsp_data),
        .i_imem_rsp_err   (rsp_err),
        .o_ifu_valid      (ifu_valid),
        .i_i2i_ready      (i2i_ready),
        .o_ifu_pc         (ifu_pc),
        .o_ifu_inst       (ifu_inst),
        .o_ifu_err        (ifu_err)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag, input logic [31:0] addr);
        int n = 0;
        while (!req_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_req_valid"}, 64'(req_valid), 64'd1);
        chk({tag, "_req_addr"}, 64'(req_addr), 64'(addr));
    endtask

    task automatic accept_req();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] pc, input logic [31:0] data,
                           input logic err, input bit keep);
        rsp_valid = 1'b1;
        rsp_data  = data;
        rsp_err   = err;
        if (keep) sb_q.push_back('{pc, err ? 32'h0000_0013 : data, err});
        tick();
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
    endtask

    task automatic take_out(input string tag, input bit jmp,
                            input logic [31:0] jpc);
        exp_t e;
        int   n = 0;
        while (!ifu_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 64'(ifu_valid), 64'd1);
        chk({tag, "_sb"}, 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_pc"}, 64'(ifu_pc), 64'(e.pc));
            chk({tag, "_inst"}, 64'(ifu_inst), 64'(e.inst));
            chk({tag, "_err"}, 64'(ifu_err), 64'(e.err));
        end
        i2i_ready = 1'b1;
        jmp_en    = jmp;
        jmp_pc    = jpc;
        tick();
        i2i_ready = 1'b0;
        jmp_en    = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [31:0] addr,
                         input logic [31:0] data);
        wait_req(tag, addr);
        accept_req();
        respond(addr, data, 1'b0, 1'b1);
        take_out(tag, 1'b0, 32'h0);
    endtask

    initial begin
        rst       = 1'b1;
        jmp_en    = 1'b0;
        jmp_pc    = '0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        i2i_ready = 1'b0;
        @(negedge clk);
        tick();

        chk("rst_req_valid", 64'(req_valid), 64'd0);
        chk("rst_req_addr", 64'(req_addr), 64'h8000_0000);
        chk("rst_ifu_valid", 64'(ifu_valid), 64'd0);
        chk("rst_ifu_pc", 64'(ifu_pc), 64'h8000_0000);
        chk("rst_ifu_inst", 64'(ifu_inst), 64'h0000_0013);
        chk("rst_ifu_err", 64'(ifu_err), 64'd0);

        // First fetch after reset, then the sequential request.
        rst = 1'b0;
        tick();
        fetch("first", 32'h8000_0000, 32'h0010_0093);
        wait_req("seq", 32'h8000_0004);

        // Request held without ready keeps its address.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("hold_addr", 64'(req_addr), 64'h8000_0004);
        end
        accept_req();
        respond(32'h8000_0004, 32'h0020_0113, 1'b0, 1'b1);

        // Backpressure in OUT: outputs stable, no new request.
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(ifu_valid), 64'd1);
            chk("bp_pc", 64'(ifu_pc), 64'h8000_0004);
            chk("bp_inst", 64'(ifu_inst), 64'h0020_0113);
            chk("bp_err", 64'(ifu_err), 64'd0);
            chk("bp_noreq", 64'(req_valid), 64'd0);
            tick();
        end
        take_out("bp", 1'b0, 32'h0);

        // Redirect during WAIT kills the in-flight response.
        wait_req("kw", 32'h8000_0008);
        accept_req();
        jmp_en = 1'b1;
        jmp_pc = 32'h8000_0102;
        tick();
        jmp_en = 1'b0;
        chk("kw_noout", 64'(ifu_valid), 64'd0);
        respond(32'h8000_0008, 32'hDEAD_0001, 1'b0, 1'b0);
        chk("kw_dropped", 64'(ifu_valid), 64'd0);
        fetch("kw_tgt", 32'h8000_0100, 32'h0030_0193);

        // Redirect together with hand-off in OUT.
        wait_req("jo", 32'h8000_0104);
        accept_req();
        respond(32'h8000_0104, 32'h0040_0213, 1'b0, 1'b1);
        take_out("jo", 1'b1, 32'h8000_0040);
        chk("jo_once", 64'(ifu_valid), 64'd0);
        fetch("jo_tgt", 32'h8000_0040, 32'h0050_0293);

        // Redirect in REQ without ready, then faulting fetch at the top.
        wait_req("jr", 32'h8000_0044);
        jmp_en = 1'b1;
        jmp_pc = 32'hFFFF_FFFC;
        tick();
        jmp_en = 1'b0;
        wait_req("err", 32'hFFFF_FFFC);
        accept_req();
        respond(32'hFFFF_FFFC, 32'hDEAD_BEEF, 1'b1, 1'b1);
        take_out("err", 1'b0, 32'h0);
        wait_req("wrap", 32'h0000_0000);

        // Redirect coinciding with a response: no kill left pending.
        accept_req();
        rsp_valid = 1'b1;
        rsp_data  = 32'hDEAD_0002;
        jmp_en    = 1'b1;
        jmp_pc    = 32'h0000_0200;
        tick();
        rsp_valid = 1'b0;
        jmp_en    = 1'b0;
        chk("jrsp_noout", 64'(ifu_valid), 64'd0);
        fetch("jrsp_tgt", 32'h0000_0200, 32'h0060_0313);

        // Redirect in REQ on the accepting cycle marks it stale.
        wait_req("jacc", 32'h0000_0204);
        req_ready = 1'b1;
        jmp_en    = 1'b1;
        jmp_pc    = 32'h0000_0300;
        tick();
        req_ready = 1'b0;
        jmp_en    = 1'b0;
        respond(32'h0000_0204, 32'hDEAD_0003, 1'b0, 1'b0);
        chk("jacc_noout", 64'(ifu_valid), 64'd0);
        wait_req("jacc_tgt", 32'h0000_0300);

        // Reset in WAIT, response arrives one cycle later.
        accept_req();
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = 32'hDEAD_0004;
        tick();
        rsp_valid = 1'b0;
        chk("rw_noout", 64'(ifu_valid), 64'd0);
        fetch("rw_fresh", 32'h8000_0000, 32'h0070_0393);

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
